// File: rtl/defender_pkg.sv
// rtl/defender_pkg.sv - shared types and ioctl index codes for the ROM download sequencer
package defender_pkg;

  typedef enum logic [1:0] {
    DL_IDLE  = 2'd0,
    DL_LOAD  = 2'd1,
    DL_DRAIN = 2'd2,
    DL_HOLD  = 2'd3
  } dl_state_t;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

endpackage

// File: rtl/dl_sequencer_if.sv
// rtl/dl_sequencer_if.sv - ioctl / ROM port / control bundle; DL_CHECKSUM_EN adds dl_sum
interface dl_sequencer_if #(parameter int NSW = 8);

  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic [15:0]       rom_addr;
  logic [7:0]        rom_data;
  logic              rom_req;
  logic              rom_ack;
  logic [7:0]        mod;
  logic [8*NSW-1:0]  dip_sw;
  logic              core_reset;
  logic              dl_busy;
  logic              overflow;
`ifdef DL_CHECKSUM_EN
  logic [15:0]       dl_sum;
`endif

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_ack,
    output ioctl_wait, rom_addr, rom_data, rom_req, mod, dip_sw, core_reset, dl_busy,
           overflow
`ifdef DL_CHECKSUM_EN
    , output dl_sum
`endif
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_ack,
    input  ioctl_wait, rom_addr, rom_data, rom_req, mod, dip_sw, core_reset, dl_busy,
           overflow
`ifdef DL_CHECKSUM_EN
    , input dl_sum
`endif
  );

endinterface

// File: rtl/dl_fifo.sv
// rtl/dl_fifo.sv - synchronous first-word fall-through FIFO for ROM writes
module dl_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign count_next = count_d;

  // A push into a full FIFO only lands when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dl_sequencer.sv
// rtl/dl_sequencer.sv - ioctl decoder, ROM write FIFO and core reset sequencer; DL_CHECKSUM_EN adds dl_sum
module dl_sequencer
  import defender_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ROM_SIZE   = 65536,
  parameter int NSW        = 8,
  parameter int RST_HOLD   = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  dl_sequencer_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] S_IDLE  = DL_IDLE;
  localparam logic [1:0] S_LOAD  = DL_LOAD;
  localparam logic [1:0] S_DRAIN = DL_DRAIN;
  localparam logic [1:0] S_HOLD  = DL_HOLD;

  logic [1:0]       state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             wait_q, wait_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       mod_q, mod_d;
  logic [8*NSW-1:0] dip_q, dip_d;

  logic             rom_wr, dip_wr, mod_wr, load_req, pop;
  logic [23:0]      fifo_head;
  logic [CW-1:0]    fifo_count, fifo_count_next;
  logic             fifo_full, fifo_empty;

  assign rom_wr   = bus.ioctl_wr && (bus.ioctl_index == IDX_ROM) &&
                    (bus.ioctl_addr < 25'(ROM_SIZE));
  assign mod_wr   = bus.ioctl_wr && (bus.ioctl_index == IDX_MOD);
  assign dip_wr   = bus.ioctl_wr && (bus.ioctl_index == IDX_DIP);
  assign load_req = bus.ioctl_download && (bus.ioctl_index == IDX_ROM);
  assign pop      = !fifo_empty && bus.rom_ack;

  dl_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(24)) u_fifo (
    .clk        (clk_sys),
    .reset      (reset),
    .push       (rom_wr),
    .push_data  ({bus.ioctl_addr[15:0], bus.ioctl_dout}),
    .pop        (pop),
    .head       (fifo_head),
    .count      (fifo_count),
    .count_next (fifo_count_next),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Stall one slot early: hps_io can have one more strobe in flight after wait rises.
  always_comb begin
    wait_d = (fifo_count_next >= CW'(FIFO_DEPTH - 1));
    ovf_d  = ovf_q || (rom_wr && fifo_full && !pop);
    mod_d  = mod_wr ? bus.ioctl_dout : mod_q;
    dip_d  = dip_q;
    if (dip_wr) begin
      for (int k = 0; k < NSW; k++) begin
        if (bus.ioctl_addr == 25'(k)) dip_d[8*k +: 8] = bus.ioctl_dout;
      end
    end
  end

  // DRAIN looks at next occupancy so the hold window starts right at the last pop.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (load_req) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!bus.ioctl_download) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (load_req) begin
          state_d = S_LOAD;
        end else if (fifo_count_next == '0) begin
          state_d = S_HOLD;
          hold_d  = 8'(RST_HOLD);
        end
      end
      S_HOLD: begin
        if (load_req) begin
          state_d = S_LOAD;
        end else if (hold_q == 8'd1) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_HOLD;
      hold_q  <= 8'(RST_HOLD);
      wait_q  <= 1'b0;
      ovf_q   <= 1'b0;
      mod_q   <= '0;
      dip_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wait_q  <= wait_d;
      ovf_q   <= ovf_d;
      mod_q   <= mod_d;
      dip_q   <= dip_d;
    end
  end

`ifdef DL_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = (state_q == S_IDLE && load_req) ? 16'd0 : sum_q;
    if (pop) sum_d = sum_d + {8'd0, fifo_head[7:0]};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign bus.dl_sum = sum_q;
`endif

  assign bus.ioctl_wait = wait_q;
  assign bus.rom_addr   = fifo_head[23:8];
  assign bus.rom_data   = fifo_head[7:0];
  assign bus.rom_req    = !fifo_empty;
  assign bus.mod        = mod_q;
  assign bus.dip_sw     = dip_q;
  assign bus.core_reset = (state_q != S_IDLE);
  assign bus.dl_busy    = (state_q != S_IDLE);
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_dl_sequencer.sv
// tb/tb_dl_sequencer.sv - directed-vector bench for dl_sequencer (DL_CHECKSUM_EN adds a dl_sum check)
module tb_dl_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  logic [23:0] exp_q[$];
  bit   wait_seen;

  always #5 clk = ~clk;

  dl_sequencer_if #(.NSW(8)) bus ();

  dl_sequencer #(
    .FIFO_DEPTH (4),
    .ROM_SIZE   (65536),
    .NSW        (8),
    .RST_HOLD   (16)
  ) dut (
    .clk_sys (clk),
    .reset   (reset),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ioctl_write(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_index = idx;
    bus.ioctl_addr  = a;
    bus.ioctl_dout  = d;
    bus.ioctl_wr    = 1'b1;
    tick();
    bus.ioctl_wr    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.dl_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(bus.dl_busy), 64'd0);
  endtask

  // Scoreboard: every accepted beat must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && bus.rom_req && bus.rom_ack) begin
      if (exp_q.size() == 0) chk("beat_unexpected", 64'(exp_q.size()), 64'd1);
      else chk("rom_beat", 64'({bus.rom_addr, bus.rom_data}), 64'(exp_q.pop_front()));
    end
    if (bus.ioctl_wait) wait_seen = 1'b1;
  end

  initial begin
    int n;
    logic [7:0] bp_wait [4];
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.rom_ack        = 1'b0;
    bp_wait = '{8'd0, 8'd0, 8'd1, 8'd1};
    repeat (3) tick();

    @(negedge clk);
    chk("rst_core_reset", 64'(bus.core_reset), 64'd1);
    chk("rst_rom_req",    64'(bus.rom_req),    64'd0);
    chk("rst_wait",       64'(bus.ioctl_wait), 64'd0);
    chk("rst_mod",        64'(bus.mod),        64'd0);
    chk("rst_dip",        64'(bus.dip_sw),     64'd0);
    chk("rst_busy",       64'(bus.dl_busy),    64'd1);
`ifdef DL_CHECKSUM_EN
    chk("rst_sum",        64'(bus.dl_sum),     64'd0);
`endif
    tick();
    reset = 1'b0;

    n = 0;
    forever begin
      @(negedge clk);
      if (!bus.core_reset || n >= 100) break;
      n++;
    end
    chk("post_reset_hold", 64'(n), 64'd16);
    chk("idle_busy", 64'(bus.dl_busy), 64'd0);

    tick();
    ioctl_write(8'd1, 25'h1234, 8'h02);
    ioctl_write(8'd254, 25'd1, 8'hA5);
    ioctl_write(8'd254, 25'd7, 8'h3C);
    ioctl_write(8'd254, 25'd9, 8'h77);
    @(negedge clk);
    chk("mod_write", 64'(bus.mod), 64'h02);
    chk("dip_write", 64'(bus.dip_sw), 64'h3C00_0000_0000_A500);
    chk("dip_nomode", 64'(bus.dl_busy), 64'd0);

    // 256 back-to-back bytes; download drops with the last strobe.
    tick();
    wait_seen = 1'b0;
    bus.rom_ack = 1'b1;
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({16'(i), 8'(i) ^ 8'hC3});
      bus.ioctl_index = 8'd0;
      bus.ioctl_addr  = 25'(i);
      bus.ioctl_dout  = 8'(i) ^ 8'hC3;
      bus.ioctl_wr    = 1'b1;
      if (i == 255) bus.ioctl_download = 1'b0;
      tick();
    end
    bus.ioctl_wr = 1'b0;
    tick();
    chk("bulk_left", 64'(exp_q.size()), 64'd0);
    n = 0;
    forever begin
      @(negedge clk);
      if (!bus.core_reset || n >= 100) break;
      n++;
    end
    chk("bulk_hold_after_pop", 64'(n), 64'd16);
    chk("bulk_wait_never", 64'(wait_seen), 64'd0);
    chk("bulk_idle", 64'(bus.dl_busy), 64'd0);

    // Back-pressure: consumer stalled, four strobes back-to-back.
    tick();
    bus.rom_ack = 1'b0;
    bus.ioctl_download = 1'b1;
    bus.ioctl_index = 8'd0;
    for (int i = 0; i < 4; i++) begin
      bus.ioctl_addr = 25'(16'h0100 + i);
      bus.ioctl_dout = 8'hA0 + 8'(i);
      bus.ioctl_wr   = 1'b1;
      tick();
      @(negedge clk);
      chk($sformatf("bp_wait_%0d", i), 64'(bus.ioctl_wait), 64'(bp_wait[i]));
      chk($sformatf("bp_req_%0d", i), 64'(bus.rom_req), 64'd1);
    end
    bus.ioctl_wr = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back({16'h0100 + 16'(i), 8'hA0 + 8'(i)});
    repeat (3) tick();
    chk("bp_head", 64'({bus.rom_addr, bus.rom_data}), 64'h0100A0);
    chk("bp_wait_hold", 64'(bus.ioctl_wait), 64'd1);
    bus.rom_ack = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_overflow", 64'(bus.overflow), 64'd0);
    chk("bp_wait_clear", 64'(bus.ioctl_wait), 64'd0);
    bus.ioctl_download = 1'b0;
    wait_idle("bp_idle");

    // Address bound: last in-range byte kept, first out-of-range byte discarded.
    tick();
    exp_q.push_back(24'hFFFF11);
    ioctl_write(8'd0, 25'h0FFFF, 8'h11);
    ioctl_write(8'd0, 25'h10000, 8'h22);
    repeat (5) tick();
    chk("bound_left", 64'(exp_q.size()), 64'd0);
    chk("bound_req", 64'(bus.rom_req), 64'd0);

`ifdef DL_CHECKSUM_EN
    bus.ioctl_download = 1'b1;
    exp_q.push_back(24'h000001);
    exp_q.push_back(24'h000102);
    exp_q.push_back(24'h0002FF);
    ioctl_write(8'd0, 25'd0, 8'h01);
    ioctl_write(8'd0, 25'd1, 8'h02);
    bus.ioctl_download = 1'b0;
    ioctl_write(8'd0, 25'd2, 8'hFF);
    repeat (4) tick();
    chk("sum_left", 64'(exp_q.size()), 64'd0);
    chk("dl_sum", 64'(bus.dl_sum), 64'h0102);
    wait_idle("sum_idle");
    chk("dl_sum_idle", 64'(bus.dl_sum), 64'h0102);
    tick();
`endif

    // Reset mid-LOAD with three entries queued.
    bus.rom_ack = 1'b0;
    bus.ioctl_download = 1'b1;
    ioctl_write(8'd0, 25'd5, 8'h55);
    ioctl_write(8'd0, 25'd6, 8'h66);
    ioctl_write(8'd0, 25'd7, 8'h77);
    @(negedge clk);
    chk("mid_req", 64'(bus.rom_req), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_rst_req",  64'(bus.rom_req),    64'd0);
    chk("mid_rst_core", 64'(bus.core_reset), 64'd1);
    chk("mid_rst_wait", 64'(bus.ioctl_wait), 64'd0);
    chk("mid_rst_mod",  64'(bus.mod),        64'd0);
    tick();
    reset = 1'b0;
    bus.ioctl_download = 1'b0;
    wait_idle("mid_idle");
    chk("mid_req_after", 64'(bus.rom_req), 64'd0);
    chk("mid_overflow",  64'(bus.overflow), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
